// File: rtl/time_set_ctrl_pkg.sv
// time_pkg: shared moduli defaults, mode encoding and auto-repeat default for time_set_ctrl
package time_pkg;
  localparam int SEC_MOD_DEF = 60;
  localparam int MIN_MOD_DEF = 60;
  localparam int HR_MOD_DEF = 24;
  localparam int REPEAT_CYCLES_DEF = 25000000;
  typedef enum logic {ST_RUN = 1'b0, ST_SET = 1'b1} state_t;
endpackage

// File: rtl/time_set_ctrl_btn_sync_edge.sv
// btn_sync_edge: STAGES-deep synchroniser for one raw input plus one-cycle rise pulse
module btn_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic sync,
  output logic rise
);
  logic [STAGES-1:0] sync_q, sync_d;
  logic [STAGES:0] chain;
  logic last_q, last_d;
  // shift the raw input one stage deeper and remember the previous synced level
  always_comb begin
    chain = {sync_q, d_in};
    sync_d = chain[STAGES-1:0];
    last_d = sync_q[STAGES-1];
  end
  // chain and edge registers
  always_ff @(posedge clk) begin
    sync_q <= rst ? '0 : sync_d;
    last_q <= rst ? 1'b0 : last_d;
  end
  // level and rise derived from the last stage
  always_comb begin
    sync = sync_q[STAGES-1];
    rise = sync_q[STAGES-1] & ~last_q;
  end
endmodule

// File: rtl/time_set_ctrl.sv
// time_set_ctrl: h/m/s timekeeper with button set mode; AUTOREPEAT_EN adds held-button auto-repeat
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int SEC_MOD = SEC_MOD_DEF,
  parameter int MIN_MOD = MIN_MOD_DEF,
  parameter int HR_MOD = HR_MOD_DEF,
  parameter int SEC_W = 6,
  parameter int MIN_W = 6,
  parameter int HR_W = 5,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_CYCLES = REPEAT_CYCLES_DEF
) (
  input  logic userclock,
  input  logic reset,
  input  logic tick,
  input  logic switch,
  input  logic switch2,
  input  logic button0,
  input  logic button2,
  input  logic button3,
  output logic [SEC_W-1:0] seconds,
  output logic [MIN_W-1:0] minutes,
  output logic [HR_W-1:0] hours,
  output logic setmode
);
  logic [4:0] raw, lvl, rise;
  logic enable, toggle, run_tick, set_ok, sec_wrap, min_wrap, hr_wrap, min_step, hr_step, rep2, rep3;
  state_t state_q, state_d;
  logic [SEC_W-1:0] sec_q, sec_d;
  logic [MIN_W-1:0] min_q, min_d;
  logic [HR_W-1:0] hr_q, hr_d;
  assign raw = {button3, button2, button0, switch2, switch};
  for (genvar i = 0; i < 5; i++) begin : g_sync
    btn_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
      .clk(userclock), .rst(reset), .d_in(raw[i]), .sync(lvl[i]), .rise(rise[i])
    );
  end
  // qualified events; a mode toggle swallows any coincident tick or increment
  always_comb begin
    enable = ~lvl[0] & ~lvl[1];
    toggle = rise[2] & enable;
    run_tick = (state_q == ST_RUN) & tick & ~toggle;
    set_ok = (state_q == ST_SET) & enable & ~toggle;
    sec_wrap = sec_q >= SEC_W'(SEC_MOD - 1);
    min_wrap = min_q >= MIN_W'(MIN_MOD - 1);
    hr_wrap = hr_q >= HR_W'(HR_MOD - 1);
    min_step = (run_tick & sec_wrap) | (set_ok & ((rise[3] & ~lvl[4]) | rep2));
    hr_step = (run_tick & sec_wrap & min_wrap) | (set_ok & ((rise[4] & ~lvl[3]) | rep3));
  end
`ifdef AUTOREPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES + 1);
  logic [RW-1:0] rep_q, rep_d;
  logic held, rep_fire;
  // count while exactly one set button is held; fire at REPEAT_CYCLES then every quarter of it
  always_comb begin
    held = set_ok & (lvl[3] ^ lvl[4]);
    rep_fire = held & (rep_q == RW'(REPEAT_CYCLES - 1));
    rep_d = !held ? '0 : rep_fire ? RW'(REPEAT_CYCLES - REPEAT_CYCLES / 4) : rep_q + 1'b1;
    rep2 = rep_fire & lvl[3];
    rep3 = rep_fire & lvl[4];
  end
  // repeat counter
  always_ff @(posedge userclock) rep_q <= reset ? '0 : rep_d;
  logic unused;
  assign unused = ^{lvl[2], rise[1:0]};
`else
  logic unused;
  assign unused = ^{lvl[2], rise[1:0], REPEAT_CYCLES[0]};
  assign rep2 = 1'b0;
  assign rep3 = 1'b0;
`endif
  // mode state register
  always_ff @(posedge userclock) state_q <= reset ? ST_RUN : state_d;
  // next mode: flip on a qualified button0 rise
  always_comb state_d = toggle ? (state_q == ST_RUN ? ST_SET : ST_RUN) : state_q;
  // mode output
  always_comb setmode = (state_q == ST_SET);
  // seconds: cleared on entry to set mode, frozen while setting
  always_comb sec_d = ((state_q == ST_RUN) & toggle) ? '0 : run_tick ? (sec_wrap ? '0 : sec_q + 1'b1) : sec_q;
  // minutes: carry from seconds in run, button step in set
  always_comb min_d = min_step ? (min_wrap ? '0 : min_q + 1'b1) : min_q;
  // hours: carry from minutes in run, button step in set
  always_comb hr_d = hr_step ? (hr_wrap ? '0 : hr_q + 1'b1) : hr_q;
  // field registers
  always_ff @(posedge userclock) begin
    sec_q <= reset ? '0 : sec_d;
    min_q <= reset ? '0 : min_d;
    hr_q <= reset ? '0 : hr_d;
  end
  assign seconds = sec_q;
  assign minutes = min_q;
  assign hours = hr_q;
endmodule

// File: tb/tb_time_set_ctrl.sv
// tb_time_set_ctrl: random and directed stimulus against a wall-clock reference model
module tb_time_set_ctrl;
  import time_pkg::*;
  localparam int SEC = 60, MIN = 60, HR = 24, S = 2;
  logic clk = 0, reset, tick;
  logic [4:0] raw;
  logic [5:0] seconds, minutes;
  logic [4:0] hours;
  logic setmode;
  int checks = 0, failures = 0;
  int ms, mm, mh, mmode, t, h0, diff;
  logic [4:0] hist[$];
  logic [4:0] c, p;
  bit en, chk_en = 0;

  time_set_ctrl #(.REPEAT_CYCLES(16)) dut (
    .userclock(clk), .reset(reset), .tick(tick), .switch(raw[0]), .switch2(raw[1]),
    .button0(raw[2]), .button2(raw[3]), .button3(raw[4]),
    .seconds(seconds), .minutes(minutes), .hours(hours), .setmode(setmode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // reference: raw inputs seen S+1 edges late, time advanced as a single count of seconds
  always @(posedge clk) begin
    if (reset) begin
      ms = 0; mm = 0; mh = 0; mmode = 0;
      hist.delete();
      repeat (S + 2) hist.push_back('0);
    end else begin
      hist.push_back(raw);
      c = hist[hist.size() - 1 - S];
      p = hist[hist.size() - 2 - S];
      void'(hist.pop_front());
      en = !c[0] && !c[1];
      if (en && c[2] && !p[2]) begin
        if (mmode == 0) ms = 0;
        mmode = 1 - mmode;
      end else if (mmode == 0) begin
        if (tick) begin
          t = ((mh * MIN + mm) * SEC + ms + 1) % (SEC * MIN * HR);
          ms = t % SEC; mm = (t / SEC) % MIN; mh = t / (SEC * MIN);
        end
      end else if (en) begin
        if (c[3] && !p[3] && !c[4]) mm = (mm + 1) % MIN;
        if (c[4] && !p[4] && !c[3]) mh = (mh + 1) % HR;
      end
    end
  end

  always @(negedge clk)
    if (chk_en)
      check("cycle", int'({setmode, hours, minutes, seconds}), (mmode << 17) | (mh << 12) | (mm << 6) | ms);

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic press(input int k, input int n);
    repeat (n) begin raw[k] = 1; cyc(1); raw[k] = 0; cyc(1); end
    cyc(S + 1);
  endtask

  initial begin
    reset = 1; tick = 0; raw = '0;
    cyc(2);
    reset = 0; chk_en = 1;
    check("reset", int'({setmode, hours, minutes, seconds}), 0);
    tick = 1; cyc(3661); tick = 0;
    check("run_h", int'(hours), 1);
    check("run_m", int'(minutes), 1);
    check("run_s", int'(seconds), 1);
    check("run_mode", int'(setmode), 0);
    press(2, 1);
    check("enter_mode", int'(setmode), 1);
    check("enter_sec", int'(seconds), 0);
    press(4, 22);
    press(3, 58);
    press(2, 1);
    check("exit_mode", int'(setmode), 0);
    tick = 1; cyc(58); tick = 0;
    check("preload", int'({hours, minutes, seconds}), (23 << 12) | (59 << 6) | 58);
    tick = 1; cyc(2); tick = 0;
    check("wrap_all", int'({hours, minutes, seconds}), 0);
    press(2, 1);
    tick = 1; press(3, 61); tick = 0;
    check("min_nocarry", int'(minutes), 1);
    check("hr_nocarry", int'(hours), 0);
    check("set_sec", int'(seconds), 0);
    raw[3] = 1; raw[4] = 1; cyc(1); raw[3] = 0; raw[4] = 0; cyc(S + 1);
    check("both_min", int'(minutes), 1);
    check("both_hr", int'(hours), 0);
    press(2, 1);
    raw[0] = 1; cyc(S + 1);
    press(2, 1);
    check("sw_block", int'(setmode), 0);
    raw[0] = 0; cyc(S + 1);
    press(2, 1);
    press(3, 36);
    check("min37", int'(minutes), 37);
    reset = 1; cyc(1);
    check("mid_reset", int'({setmode, hours, minutes, seconds}), 0);
    reset = 0;
    tick = 1; cyc(5); tick = 0;
    raw[2] = 1; cyc(1); raw[2] = 0; cyc(S - 1);
    tick = 1; cyc(1); tick = 0;
    check("coinc_mode", int'(setmode), 1);
    check("coinc_sec", int'(seconds), 0);
    press(2, 1);
    repeat (1500) begin
      tick = $urandom_range(0, 1);
      raw[0] = ($urandom_range(0, 7) == 0);
      raw[1] = ($urandom_range(0, 7) == 0);
      for (int k = 2; k < 5; k++) raw[k] = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    raw = '0; tick = 0;
    reset = 1; cyc(1); reset = 0;
    press(2, 1);
    check("rep_mode", int'(setmode), 1);
    chk_en = 0;
    h0 = int'(hours);
    raw[4] = 1; cyc(40); raw[4] = 0; cyc(S + 2);
    diff = (int'(hours) - h0 + HR) % HR;
`ifdef AUTOREPEAT_EN
    check("rep_hold", int'(diff >= 7 && diff <= 9), 1);
`else
    check("rep_hold", diff, 1);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
